cte_yuv_unpacker: RTL and testbench

//  Input stage of the CTE colour-transform engine. It sits directly upstream of the YUV->RGB

---
 rtl/cte_pkg.sv | 23 ++
 rtl/cte_yuv_unpacker.sv | 120 ++++++++++++
 tb/tb_cte_yuv_unpacker.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cte_pkg.sv
// Shared types for the CTE colour-transform engine: byte-phase enum and pixel triple.
package cte_pkg;

    typedef enum logic [1:0] {
        PH_U  = 2'd0,
        PH_Y0 = 2'd1,
        PH_V  = 2'd2,
        PH_Y1 = 2'd3
    } phase_e;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] u;
        logic [7:0] v;
    } yuv_pix_t;

    localparam int N_PIX_DEFAULT = 500;

    function automatic phase_e next_phase(input phase_e p);
        return phase_e'(p + 2'd1);
    endfunction

endpackage

// File: rtl/cte_yuv_unpacker.sv
// Unpacks a 4:2:2 byte stream (U Y0 V Y1) into (Y,U,V) pixel triples with
// a two-stage buffer: stage A assembles a group, stage B presents its two pixels.
module cte_yuv_unpacker
    import cte_pkg::*;
#(
    parameter int N_PIX = N_PIX_DEFAULT,
    parameter int IDX_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_en,
    input  logic [7:0]       yuv_in,
    output logic             busy,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [7:0]       pix_y,
    output logic [7:0]       pix_u,
    output logic [7:0]       pix_v,
    output logic [IDX_W-1:0] pix_idx,
    output logic             pix_last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIX - 1);

    phase_e     phase;
    logic [7:0] a_u, a_y0, a_v, a_y1;
    logic       a_full;
    logic [7:0] b_u, b_y0, b_v, b_y1;
    logic [1:0] out_cnt;

    logic transfer;
    logic b_free;
    logic capture;
    logic y1_cap;
    logic load_from_in;
    logic load_from_a;

    assign pix_valid    = (out_cnt != 2'd0);
    assign transfer     = pix_valid & pix_ready;
    assign b_free       = (out_cnt == 2'd0) | ((out_cnt == 2'd1) & transfer);
    assign capture      = in_en & ~a_full;
    assign y1_cap       = capture & (phase == PH_Y1);
    assign load_from_in = y1_cap & b_free;
    assign load_from_a  = a_full & b_free;

    // First pixel of a pair uses Y0, second uses Y1; chroma is shared.
    assign pix_y    = (out_cnt == 2'd2) ? b_y0 : b_y1;
    assign pix_u    = b_u;
    assign pix_v    = b_v;
    assign pix_last = pix_valid & (pix_idx == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= PH_U;
        end else if (capture) begin
            phase <= next_phase(phase);
        end
    end

    // Stage A: byte capture; a completed group parks here when B is still busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_u    <= 8'd0;
            a_y0   <= 8'd0;
            a_v    <= 8'd0;
            a_y1   <= 8'd0;
            a_full <= 1'b0;
            busy   <= 1'b0;
        end else begin
            if (capture) begin
                case (phase)
                    PH_U:    a_u  <= yuv_in;
                    PH_Y0:   a_y0 <= yuv_in;
                    PH_V:    a_v  <= yuv_in;
                    default: a_y1 <= yuv_in;
                endcase
            end
            if (y1_cap && !b_free) begin
                a_full <= 1'b1;
                busy   <= 1'b1;
            end else if (load_from_a) begin
                a_full <= 1'b0;
                busy   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b_u     <= 8'd0;
            b_y0    <= 8'd0;
            b_v     <= 8'd0;
            b_y1    <= 8'd0;
            out_cnt <= 2'd0;
        end else if (load_from_in) begin
            b_u     <= a_u;
            b_y0    <= a_y0;
            b_v     <= a_v;
            b_y1    <= yuv_in;
            out_cnt <= 2'd2;
        end else if (load_from_a) begin
            b_u     <= a_u;
            b_y0    <= a_y0;
            b_v     <= a_v;
            b_y1    <= a_y1;
            out_cnt <= 2'd2;
        end else if (transfer) begin
            out_cnt <= out_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_idx <= '0;
        end else if (transfer) begin
            pix_idx <= (pix_idx == LAST_IDX) ? '0 : pix_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_cte_yuv_unpacker.sv
// Directed and random-ready bench for cte_yuv_unpacker with a pixel scoreboard.
module tb_cte_yuv_unpacker;
    import cte_pkg::*;

    localparam int N_PIX = 500;
    localparam int IDX_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_en = 1'b0;
    logic [7:0]       yuv_in = 8'h00;
    logic             pix_ready = 1'b0;
    logic             busy;
    logic             pix_valid;
    logic [7:0]       pix_y, pix_u, pix_v;
    logic [IDX_W-1:0] pix_idx;
    logic             pix_last;

    int       checks = 0;
    int       errors = 0;
    yuv_pix_t sb_q[$];
    int       exp_idx = 0;
    int       last_cnt = 0;
    bit       mon_en = 1'b0;
    bit       no_busy = 1'b0;
    int       m_phase = 0;
    logic [7:0] m_u, m_y0, m_v;

    cte_yuv_unpacker #(.N_PIX(N_PIX), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .in_en(in_en), .yuv_in(yuv_in), .busy(busy),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_y(pix_y), .pix_u(pix_u),
        .pix_v(pix_v), .pix_idx(pix_idx), .pix_last(pix_last)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference assembly: pushes both pixels of a group once its Y1 is accepted.
    task automatic model_accept(input logic [7:0] b);
        case (m_phase)
            0: m_u = b;
            1: m_y0 = b;
            2: m_v = b;
            default: begin
                sb_q.push_back('{y: m_y0, u: m_u, v: m_v});
                sb_q.push_back('{y: b, u: m_u, v: m_v});
            end
        endcase
        m_phase = (m_phase + 1) % 4;
    endtask

    task automatic apply_stimulus(input bit en, input logic [7:0] b, input bit rdy, input bit accept);
        @(posedge clk);
        #1;
        in_en = en;
        yuv_in = b;
        pix_ready = rdy;
        if (en && accept) model_accept(b);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        reset = 1'b1;
        in_en = 1'b0;
        pix_ready = 1'b0;
        sb_q.delete();
        m_phase = 0;
        exp_idx = 0;
        @(negedge clk);
        check_output("rst_busy", busy, 0);
        check_output("rst_valid", pix_valid, 0);
        check_output("rst_y", pix_y, 0);
        check_output("rst_u", pix_u, 0);
        check_output("rst_v", pix_v, 0);
        check_output("rst_idx", pix_idx, 0);
        check_output("rst_last", pix_last, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        apply_stimulus(1'b0, 8'hA5, 1'b1, 1'b0);
        while ((sb_q.size() != 0 || pix_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, sb_q.size(), 0);
    endtask

    // Scoreboard monitor: presented pixel must equal the queue head, held until taken.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (no_busy) check_output("busy_idle", busy, 0);
            if (pix_valid) begin
                check_output("spurious_valid", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    check_output("pix_y", pix_y, sb_q[0].y);
                    check_output("pix_u", pix_u, sb_q[0].u);
                    check_output("pix_v", pix_v, sb_q[0].v);
                    check_output("pix_idx", pix_idx, exp_idx);
                    check_output("pix_last", pix_last, exp_idx == N_PIX - 1);
                    if (pix_ready) begin
                        void'(sb_q.pop_front());
                        if (pix_last) last_cnt++;
                        exp_idx = (exp_idx == N_PIX - 1) ? 0 : exp_idx + 1;
                    end
                end
            end else begin
                check_output("last_idle", pix_last, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int sent;
        int cyc;
        do_reset();

        // Basic pair with ready high; first pixel one clock after Y1.
        no_busy = 1'b1;
        apply_stimulus(1'b1, 8'h80, 1'b1, 1'b1);
        apply_stimulus(1'b1, 8'h10, 1'b1, 1'b1);
        apply_stimulus(1'b1, 8'h7F, 1'b1, 1'b1);
        apply_stimulus(1'b1, 8'h20, 1'b1, 1'b1);
        @(negedge clk);
        check_output("t1_latency_pre", pix_valid, 0);
        apply_stimulus(1'b0, 8'hA5, 1'b1, 1'b0);
        @(negedge clk);
        check_output("t1_latency", pix_valid, 1);
        check_output("t1_first_y", pix_y, 8'h10);
        wait_drain("t1_drain");
        check_output("t1_count", exp_idx, 2);

        // Backpressure: A fills, busy rises, ninth byte is dropped.
        no_busy = 1'b0;
        apply_stimulus(1'b1, 8'h01, 1'b0, 1'b1);
        apply_stimulus(1'b1, 8'h11, 1'b0, 1'b1);
        apply_stimulus(1'b1, 8'h02, 1'b0, 1'b1);
        apply_stimulus(1'b1, 8'h12, 1'b0, 1'b1);
        apply_stimulus(1'b1, 8'h03, 1'b0, 1'b1);
        apply_stimulus(1'b1, 8'h13, 1'b0, 1'b1);
        apply_stimulus(1'b1, 8'h04, 1'b0, 1'b1);
        apply_stimulus(1'b1, 8'h14, 1'b0, 1'b1);
        apply_stimulus(1'b1, 8'h55, 1'b0, 1'b0);
        @(negedge clk);
        check_output("t2_busy_set", busy, 1);
        apply_stimulus(1'b0, 8'hA5, 1'b1, 1'b0);
        @(negedge clk);
        check_output("t2_busy_hold0", busy, 1);
        @(negedge clk);
        check_output("t2_busy_hold1", busy, 1);
        @(negedge clk);
        check_output("t2_busy_clear", busy, 0);
        wait_drain("t2_drain");

        // Gaps between bytes: phase advances only on in_en.
        no_busy = 1'b1;
        apply_stimulus(1'b1, 8'h90, 1'b1, 1'b1);
        apply_stimulus(1'b0, 8'hEE, 1'b1, 1'b0);
        apply_stimulus(1'b0, 8'hDD, 1'b1, 1'b0);
        apply_stimulus(1'b1, 8'hC0, 1'b1, 1'b1);
        apply_stimulus(1'b0, 8'hCC, 1'b1, 1'b0);
        apply_stimulus(1'b1, 8'h70, 1'b1, 1'b1);
        apply_stimulus(1'b0, 8'hBB, 1'b1, 1'b0);
        apply_stimulus(1'b0, 8'hAA, 1'b1, 1'b0);
        apply_stimulus(1'b1, 8'hF0, 1'b1, 1'b1);
        wait_drain("t4_drain");

        // Y1 capture on the same edge as the last-pixel transfer.
        apply_stimulus(1'b1, 8'h21, 1'b0, 1'b1);
        apply_stimulus(1'b1, 8'h31, 1'b0, 1'b1);
        apply_stimulus(1'b1, 8'h22, 1'b0, 1'b1);
        apply_stimulus(1'b1, 8'h32, 1'b0, 1'b1);
        apply_stimulus(1'b1, 8'h23, 1'b0, 1'b1);
        apply_stimulus(1'b1, 8'h33, 1'b0, 1'b1);
        apply_stimulus(1'b1, 8'h24, 1'b0, 1'b1);
        apply_stimulus(1'b0, 8'hA5, 1'b1, 1'b0);
        apply_stimulus(1'b1, 8'h34, 1'b1, 1'b1);
        @(negedge clk);
        check_output("t6_pre", pix_valid, 1);
        apply_stimulus(1'b0, 8'hA5, 1'b1, 1'b0);
        @(negedge clk);
        check_output("t6_no_bubble", pix_valid, 1);
        check_output("t6_reload_y", pix_y, 8'h33);
        wait_drain("t6_drain");

        // Reset mid-group with one pixel pending in B.
        apply_stimulus(1'b1, 8'h41, 1'b0, 1'b1);
        apply_stimulus(1'b1, 8'h51, 1'b0, 1'b1);
        apply_stimulus(1'b1, 8'h42, 1'b0, 1'b1);
        apply_stimulus(1'b1, 8'h52, 1'b0, 1'b1);
        apply_stimulus(1'b0, 8'hA5, 1'b1, 1'b0);
        apply_stimulus(1'b1, 8'h43, 1'b0, 1'b1);
        apply_stimulus(1'b1, 8'h53, 1'b0, 1'b1);
        do_reset();
        apply_stimulus(1'b1, 8'h61, 1'b1, 1'b1);
        apply_stimulus(1'b1, 8'h71, 1'b1, 1'b1);
        apply_stimulus(1'b1, 8'h62, 1'b1, 1'b1);
        apply_stimulus(1'b1, 8'h72, 1'b1, 1'b1);
        wait_drain("t5_drain");
        check_output("t5_count", exp_idx, 2);

        // Full frame with random ready; source honours busy.
        no_busy = 1'b0;
        do_reset();
        last_cnt = 0;
        sent = 0;
        cyc = 0;
        while (sent < 2 * N_PIX && cyc < 20000) begin
            @(posedge clk);
            #1;
            pix_ready = ($urandom_range(0, 3) != 0);
            if (!busy && $urandom_range(0, 3) != 0) begin
                in_en = 1'b1;
                yuv_in = 8'($urandom);
                model_accept(yuv_in);
                sent++;
            end else begin
                in_en = 1'b0;
            end
            cyc++;
        end
        check_output("t3_sent", sent, 2 * N_PIX);
        wait_drain("t3_drain");
        check_output("t3_last_count", last_cnt, 1);
        check_output("t3_wrapped", exp_idx, 0);
        apply_stimulus(1'b1, 8'h81, 1'b1, 1'b1);
        apply_stimulus(1'b1, 8'h91, 1'b1, 1'b1);
        apply_stimulus(1'b1, 8'h82, 1'b1, 1'b1);
        apply_stimulus(1'b1, 8'h92, 1'b1, 1'b1);
        wait_drain("t3_next_frame");
        check_output("t3_next_idx", exp_idx, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
